// File: rtl/expr_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// expr_ctrl_pkg
//   Shared definitions for the expression-stream controller: the sequencer
//   state encoding, the result error codes and the requester count.
//   Imported by expr_rr_arb2 and expr_stream_ctrl.
// ---------------------------------------------------------------------------
package expr_ctrl_pkg;

    // Number of byte-stream requesters sharing the recognizer.
    localparam int NREQ = 2;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_CLR     = 3'd2,
        ST_BURST   = 3'd3,
        ST_CHECK   = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // Result error codes reported on res_err.
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

    // One-hot select mask for a requester id.
    function automatic logic [NREQ-1:0] id_mask(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/expr_rr_arb2.sv
// ---------------------------------------------------------------------------
// expr_rr_arb2
//   Two-way round-robin arbiter. When both requesters are asking, the one
//   that was not granted last wins. The pointer moves only when the
//   candidate grant is actually taken. After reset requester 0 is favoured.
//
// Ports
//   clk      in   clock
//   clr_n    in   asynchronous active-low reset
//   req      in   [NREQ-1:0] request lines
//   take     in   caller takes the presented grant this cycle
//   gnt_any  out  at least one request present
//   gnt_id   out  id of the requester that would be granted
// ---------------------------------------------------------------------------
module expr_rr_arb2
    import expr_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            clr_n,
    input  logic [NREQ-1:0] req,
    input  logic            take,
    output logic            gnt_any,
    output logic            gnt_id
);

    // Id granted most recently; resetting to 1 makes requester 0 win a tie.
    logic last_q;

    always_comb begin
        gnt_any = |req;
        unique case (req)
            2'b11:   gnt_id = ~last_q;
            2'b10:   gnt_id = 1'b1;
            default: gnt_id = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            last_q <= 1'b1;
        end else if (take && gnt_any) begin
            last_q <= gnt_id;
        end
    end

endmodule

// File: rtl/expr_stream_ctrl.sv
// ---------------------------------------------------------------------------
// expr_stream_ctrl
//   Shares one character-stream expression recognizer between two byte-stream
//   requesters. A requester is granted for a whole string (round-robin), the
//   string is buffered, the recognizer is cleared for one cycle, the buffered
//   bytes are replayed back-to-back, and the recognizer verdict is returned
//   as a single-cycle result pulse. Strings longer than MAX_LEN bytes are
//   reported as overflow without touching the recognizer.
//
// Build option
//   EXPR_TIMEOUT_EN  when defined, a string whose owner stays idle for
//                    TIMEOUT consecutive cycles is aborted with a timeout
//                    error and the grant is released. When undefined the
//                    controller waits forever and res_err[1] is always 0.
//
// Parameters
//   MAX_LEN   bytes buffered per string (>= 2)
//   TIMEOUT   idle cycles tolerated mid-string (EXPR_TIMEOUT_EN only)
//
// Ports
//   clk        in   clock, all logic on the rising edge
//   clr_n      in   asynchronous active-low reset
//   req_valid  in   [1:0]  requester i has a byte
//   req_data   in   [15:0] byte of requester i at [8i+:8]
//   req_last   in   [1:0]  byte ends its string
//   req_ready  out  [1:0]  byte of requester i accepted this cycle
//   rec_clr    out  recognizer clear, active-high
//   rec_in     out  [7:0]  character presented to the recognizer
//   rec_out    in   recognizer accept output (registered in the recognizer)
//   res_valid  out  one-cycle result pulse
//   res_ok     out  string accepted
//   res_id     out  requester that owned the string
//   res_len    out  bytes accepted, saturating at MAX_LEN
//   res_err    out  [1:0] 00 none, 01 overflow, 10 timeout
// ---------------------------------------------------------------------------
module expr_stream_ctrl
    import expr_ctrl_pkg::*;
#(
    parameter int MAX_LEN = 16
`ifdef EXPR_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 64
`endif
) (
    input  logic                         clk,
    input  logic                         clr_n,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [8*NREQ-1:0]            req_data,
    input  logic [NREQ-1:0]              req_last,
    output logic [NREQ-1:0]              req_ready,
    output logic                         rec_clr,
    output logic [7:0]                   rec_in,
    input  logic                         rec_out,
    output logic                         res_valid,
    output logic                         res_ok,
    output logic                         res_id,
    output logic [$clog2(MAX_LEN+1)-1:0] res_len,
    output logic [1:0]                   res_err
);

    localparam int             CW      = $clog2(MAX_LEN + 1);
    localparam int             IW      = $clog2(MAX_LEN);
    localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_LEN);

`ifdef EXPR_TIMEOUT_EN
    localparam int             TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0]             idle_q;
`endif

    state_e          state_q;
    logic            grant_q;
    logic [CW-1:0]   cnt_q;
    logic            ovf_q;
    logic [CW-1:0]   burst_q;
    logic [7:0]      buf_q [MAX_LEN];

    logic            rec_clr_q;
    logic [7:0]      rec_in_q;
    logic            res_valid_q;
    logic            res_ok_q;
    logic            res_id_q;
    logic [CW-1:0]   res_len_q;
    logic [1:0]      res_err_q;

    logic            arb_any;
    logic            arb_id;
    logic            accept;
    logic            byte_last;
    logic [7:0]      byte_g;
    logic            cnt_full;

    expr_rr_arb2 u_arb (
        .clk     (clk),
        .clr_n   (clr_n),
        .req     (req_valid),
        .take    (state_q == ST_IDLE),
        .gnt_any (arb_any),
        .gnt_id  (arb_id)
    );

    // Only the granted requester is ever ready, and only while collecting.
    always_comb begin
        accept    = (state_q == ST_COLLECT) && req_valid[grant_q];
        byte_last = req_last[grant_q];
        byte_g    = grant_q ? req_data[8 +: 8] : req_data[0 +: 8];
        cnt_full  = (cnt_q == MAX_CNT);
        req_ready = (state_q == ST_COLLECT) ? (req_valid & id_mask(grant_q)) : '0;
    end

    // String buffer; bytes past MAX_LEN are dropped, so no reset is needed.
    always_ff @(posedge clk) begin
        if (accept && !cnt_full) begin
            buf_q[cnt_q[IW-1:0]] <= byte_g;
        end
    end

    // Sequencer. Every output is registered and is set on the edge that
    // enters the state in which it must be seen.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= 1'b0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            burst_q     <= '0;
            rec_clr_q   <= 1'b1;
            rec_in_q    <= 8'h00;
            res_valid_q <= 1'b0;
            res_ok_q    <= 1'b0;
            res_id_q    <= 1'b0;
            res_len_q   <= '0;
            res_err_q   <= ERR_NONE;
`ifdef EXPR_TIMEOUT_EN
            idle_q      <= '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    rec_clr_q <= 1'b0;
                    if (arb_any) begin
                        grant_q <= arb_id;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
`ifdef EXPR_TIMEOUT_EN
                        idle_q  <= '0;
`endif
                        state_q <= ST_COLLECT;
                    end
                end

                ST_COLLECT: begin
                    if (accept) begin
                        if (cnt_full) begin
                            ovf_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
`ifdef EXPR_TIMEOUT_EN
                        idle_q <= '0;
`endif
                        // A last byte arriving at a full buffer is itself
                        // the overflowing byte, so ovf_q is not yet set.
                        if (byte_last) begin
                            if (ovf_q || cnt_full) begin
                                res_valid_q <= 1'b1;
                                res_ok_q    <= 1'b0;
                                res_id_q    <= grant_q;
                                res_len_q   <= cnt_q;
                                res_err_q   <= ERR_OVF;
                                state_q     <= ST_DONE;
                            end else begin
                                rec_clr_q <= 1'b1;
                                state_q   <= ST_CLR;
                            end
                        end
                    end
`ifdef EXPR_TIMEOUT_EN
                    else if (idle_q == TMO_LAST) begin
                        res_valid_q <= 1'b1;
                        res_ok_q    <= 1'b0;
                        res_id_q    <= grant_q;
                        res_len_q   <= cnt_q;
                        res_err_q   <= ERR_TMO;
                        state_q     <= ST_DONE;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
`endif
                end

                ST_CLR: begin
                    rec_clr_q <= 1'b0;
                    rec_in_q  <= buf_q[0];
                    burst_q   <= CW'(1);
                    state_q   <= ST_BURST;
                end

                // burst_q is the index of the byte to present next cycle.
                ST_BURST: begin
                    if (burst_q == cnt_q) begin
                        state_q <= ST_CHECK;
                    end else begin
                        rec_in_q <= buf_q[burst_q[IW-1:0]];
                        burst_q  <= burst_q + 1'b1;
                    end
                end

                // rec_out now reflects the last replayed byte.
                ST_CHECK: begin
                    res_valid_q <= 1'b1;
                    res_ok_q    <= rec_out;
                    res_id_q    <= grant_q;
                    res_len_q   <= cnt_q;
                    res_err_q   <= ERR_NONE;
                    state_q     <= ST_DONE;
                end

                ST_DONE: begin
                    res_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rec_clr   = rec_clr_q;
    assign rec_in    = rec_in_q;
    assign res_valid = res_valid_q;
    assign res_ok    = res_ok_q;
    assign res_id    = res_id_q;
    assign res_len   = res_len_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_expr_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_expr_stream_ctrl
//   Directed bench for expr_stream_ctrl built with MAX_LEN=8 (and
//   TIMEOUT=16 when EXPR_TIMEOUT_EN is defined). A small behavioural
//   recognizer accepts well-formed expressions of single digits, '+', '*'
//   and parentheses; its output is registered like the real one.
// ---------------------------------------------------------------------------
module tb_expr_stream_ctrl;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        rec_clr;
    logic [7:0]  rec_in;
    logic        rec_out;
    logic        res_valid;
    logic        res_ok;
    logic        res_id;
    logic [3:0]  res_len;
    logic [1:0]  res_err;

    logic        vld0 = 1'b0, vld1 = 1'b0;
    logic [7:0]  dat0 = 8'h00, dat1 = 8'h00;
    logic        lst0 = 1'b0, lst1 = 1'b0;

    assign req_valid = {vld1, vld0};
    assign req_data  = {dat1, dat0};
    assign req_last  = {lst1, lst0};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int first_acc_cyc = 0;
    int clr_hi = 0;

    typedef struct packed {
        logic       ok;
        logic       id;
        logic [3:0] len;
        logic [1:0] err;
        int         cyc;
    } res_t;

    res_t rlog[$];
    res_t mon_r;

    expr_stream_ctrl #(
        .MAX_LEN(8)
`ifdef EXPR_TIMEOUT_EN
        ,
        .TIMEOUT(16)
`endif
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .rec_clr   (rec_clr),
        .rec_in    (rec_in),
        .rec_out   (rec_out),
        .res_valid (res_valid),
        .res_ok    (res_ok),
        .res_id    (res_id),
        .res_len   (res_len),
        .res_err   (res_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Recognizer model: consumes rec_in every cycle, clear has priority.
    logic rm_opnd = 1'b1;
    logic rm_err = 1'b0;
    int   rm_depth = 0;

    always @(posedge clk) begin
        if (rec_clr) begin
            rm_opnd  <= 1'b1;
            rm_depth <= 0;
            rm_err   <= 1'b0;
        end else if (!rm_err) begin
            if (rm_opnd) begin
                if (rec_in >= 8'h30 && rec_in <= 8'h39) rm_opnd <= 1'b0;
                else if (rec_in == 8'h28) rm_depth <= rm_depth + 1;
                else rm_err <= 1'b1;
            end else begin
                if (rec_in == 8'h2B || rec_in == 8'h2A) rm_opnd <= 1'b1;
                else if (rec_in == 8'h29 && rm_depth > 0) rm_depth <= rm_depth - 1;
                else rm_err <= 1'b1;
            end
        end
    end

    assign rec_out = !rm_err && !rm_opnd && (rm_depth == 0);

    // Result and rec_clr monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rec_clr) clr_hi <= clr_hi + 1;
        if (clr_n && res_valid) begin
            mon_r.ok  = res_ok;
            mon_r.id  = res_id;
            mon_r.len = res_len;
            mon_r.err = res_err;
            mon_r.cyc = cyc;
            rlog.push_back(mon_r);
        end
    end

    task automatic drive(input int r, input logic v, input logic [7:0] d, input logic l);
        if (r == 0) begin
            vld0 = v; dat0 = d; lst0 = l;
        end else begin
            vld1 = v; dat1 = d; lst1 = l;
        end
    endtask

    // Sends a string from requester r; called on a falling edge.
    task automatic send_str(input int r, input string s, input bit with_last);
        int guard;
        for (int i = 0; i < s.len(); i++) begin
            drive(r, 1'b1, s[i], with_last && (i == s.len() - 1));
            #1;
            guard = 0;
            while (!req_ready[r]) begin
                @(negedge clk);
                #1;
                guard++;
                if (guard > 300) begin
                    n_cmp++;
                    n_bad++;
                    $display("[TB] FAIL send_ready req%0d byte %0d: ready never seen, required 1", r, i);
                    drive(r, 1'b0, 8'h00, 1'b0);
                    return;
                end
            end
            if (i == 0) first_acc_cyc = cyc;
            @(negedge clk);
        end
        drive(r, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_res(input int target, input string tag);
        int g = 0;
        while (rlog.size() < target && g < 400) begin
            @(negedge clk);
            g++;
        end
        n_cmp++;
        if (rlog.size() < target) begin
            n_bad++;
            $display("[TB] FAIL %s: results seen %0d, required %0d", tag, rlog.size(), target);
        end
    endtask

    task automatic check_res(input int idx, input string tag, input logic ok,
                             input logic id, input logic [3:0] len, input logic [1:0] err);
        if (rlog.size() > idx) begin
            n_cmp++;
            if (rlog[idx].ok !== ok) begin
                n_bad++;
                $display("[TB] FAIL %s ok: got %0b, required %0b", tag, rlog[idx].ok, ok);
            end
            n_cmp++;
            if (rlog[idx].id !== id) begin
                n_bad++;
                $display("[TB] FAIL %s id: got %0b, required %0b", tag, rlog[idx].id, id);
            end
            n_cmp++;
            if (rlog[idx].len !== len) begin
                n_bad++;
                $display("[TB] FAIL %s len: got %0d, required %0d", tag, rlog[idx].len, len);
            end
            n_cmp++;
            if (rlog[idx].err !== err) begin
                n_bad++;
                $display("[TB] FAIL %s err: got %b, required %b", tag, rlog[idx].err, err);
            end
        end
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        drive(0, 1'b1, 8'h31, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (req_ready !== 2'b00) begin n_bad++; $display("[TB] FAIL reset req_ready: got %b, required 00", req_ready); end
        n_cmp++;
        if (rec_clr !== 1'b1) begin n_bad++; $display("[TB] FAIL reset rec_clr: got %b, required 1", rec_clr); end
        n_cmp++;
        if (rec_in !== 8'h00) begin n_bad++; $display("[TB] FAIL reset rec_in: got %h, required 00", rec_in); end
        n_cmp++;
        if ({res_valid, res_ok, res_id, res_len, res_err} !== 9'd0) begin
            n_bad++;
            $display("[TB] FAIL reset res: got %b%b%b %0d %b, required all 0", res_valid, res_ok, res_id, res_len, res_err);
        end
        drive(0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (rec_clr !== 1'b0) begin n_bad++; $display("[TB] FAIL idle rec_clr: got %b, required 0", rec_clr); end
    endtask

    task automatic test_single();
        int b = rlog.size();
        int c0;
        @(negedge clk);
        c0 = clr_hi;
        send_str(0, "1+2", 1'b1);
        wait_res(b + 1, "single result");
        check_res(b, "single", 1'b1, 1'b0, 4'd3, 2'b00);
        if (rlog.size() > b) begin
            n_cmp++;
            if (rlog[b].cyc - first_acc_cyc !== 8) begin
                n_bad++;
                $display("[TB] FAIL single latency: got %0d, required 8", rlog[b].cyc - first_acc_cyc);
            end
        end
        n_cmp++;
        if (clr_hi - c0 !== 1) begin n_bad++; $display("[TB] FAIL single rec_clr cycles: got %0d, required 1", clr_hi - c0); end
        n_cmp++;
        if (rec_in !== 8'h32) begin n_bad++; $display("[TB] FAIL single rec_in hold: got %h, required 32", rec_in); end
    endtask

    task automatic test_reject_accept();
        int b = rlog.size();
        @(negedge clk);
        send_str(1, "(1+2", 1'b1);
        wait_res(b + 1, "reject result");
        check_res(b, "reject", 1'b0, 1'b1, 4'd4, 2'b00);
        @(negedge clk);
        send_str(1, "(1*2)", 1'b1);
        wait_res(b + 2, "accept result");
        check_res(b + 1, "accept", 1'b1, 1'b1, 4'd5, 2'b00);
    endtask

    task automatic test_back_to_back();
        int b;
        @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        b = rlog.size();
        fork
            begin send_str(0, "5", 1'b1); send_str(0, "5", 1'b1); end
            begin send_str(1, "5", 1'b1); send_str(1, "5", 1'b1); end
        join
        wait_res(b + 4, "b2b results");
        for (int i = 0; i < 4; i++) begin
            check_res(b + i, "b2b", 1'b1, ((i % 2) == 1), 4'd1, 2'b00);
        end
    endtask

    task automatic test_overflow();
        int b = rlog.size();
        int c0;
        logic [7:0] rin0;
        @(negedge clk);
        c0 = clr_hi;
        rin0 = rec_in;
        send_str(0, "1+2+3+4+5", 1'b1);
        wait_res(b + 1, "ovf result");
        check_res(b, "ovf", 1'b0, 1'b0, 4'd8, 2'b01);
        n_cmp++;
        if (clr_hi - c0 !== 0) begin n_bad++; $display("[TB] FAIL ovf rec_clr cycles: got %0d, required 0", clr_hi - c0); end
        n_cmp++;
        if (rec_in !== rin0) begin n_bad++; $display("[TB] FAIL ovf rec_in: got %h, required %h", rec_in, rin0); end
        @(negedge clk);
        c0 = clr_hi;
        send_str(0, "1+2+3+4)", 1'b1);
        wait_res(b + 2, "full result");
        check_res(b + 1, "full", 1'b0, 1'b0, 4'd8, 2'b00);
        n_cmp++;
        if (clr_hi - c0 !== 1) begin n_bad++; $display("[TB] FAIL full rec_clr cycles: got %0d, required 1", clr_hi - c0); end
    endtask

    task automatic test_reset_mid_burst();
        int b = rlog.size();
        int g = 0;
        @(negedge clk);
        send_str(0, "7*8", 1'b1);
        while (!rec_clr && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        n_cmp++;
        if (rec_in !== 8'h37) begin n_bad++; $display("[TB] FAIL burst first byte: got %h, required 37", rec_in); end
        clr_n = 1'b0;
        #1;
        n_cmp++;
        if ({rec_clr, rec_in, res_valid} !== {1'b1, 8'h00, 1'b0}) begin
            n_bad++;
            $display("[TB] FAIL midreset outputs: got clr=%b in=%h valid=%b, required 1 00 0", rec_clr, rec_in, res_valid);
        end
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (rlog.size() !== b) begin n_bad++; $display("[TB] FAIL midreset results: got %0d, required %0d", rlog.size(), b); end
        send_str(0, "9", 1'b1);
        wait_res(b + 1, "after reset result");
        check_res(b, "after reset", 1'b1, 1'b0, 4'd1, 2'b00);
    endtask

`ifdef EXPR_TIMEOUT_EN
    task automatic test_timeout();
        int b = rlog.size();
        @(negedge clk);
        send_str(0, "1+", 1'b0);
        send_str(1, "9", 1'b1);
        wait_res(b + 2, "timeout results");
        check_res(b, "timeout", 1'b0, 1'b0, 4'd2, 2'b10);
        check_res(b + 1, "post timeout", 1'b1, 1'b1, 4'd1, 2'b00);
    endtask
`else
    task automatic test_no_timeout();
        int b = rlog.size();
        @(negedge clk);
        send_str(0, "1+", 1'b0);
        repeat (80) @(negedge clk);
        n_cmp++;
        if (rlog.size() !== b) begin n_bad++; $display("[TB] FAIL idle wait results: got %0d, required %0d", rlog.size(), b); end
        send_str(0, "3", 1'b1);
        wait_res(b + 1, "resumed result");
        check_res(b, "resumed", 1'b1, 1'b0, 4'd3, 2'b00);
    endtask
`endif

    initial begin
        $display("[TB] start");
        test_reset();
        test_single();
        test_reject_accept();
        test_back_to_back();
        test_overflow();
        test_reset_mid_burst();
`ifdef EXPR_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
